// File: rtl/pim_readout_ctrl_if.sv
// Readout bus of the PIM array sequencer.
// Groups the array-side strobes (rd_en/rd_addr, shift_adder clear/enable), the relu result
// input and the downstream valid/ready output stream.
//   master: the sequencer (drives strobes and the output stream, reads relu_in/o_ready)
//   slave : the datapath/downstream side (drives relu_in and o_ready)
interface pim_readout_ctrl_if #(
  parameter int unsigned CHANNEL = 10,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CNT_W   = 8
) ();
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     sa_clr;
  logic                     sa_en;
  logic [CHANNEL*OUT_W-1:0] relu_in;
  logic                     o_valid;
  logic                     o_ready;
  logic [CHANNEL*OUT_W-1:0] o_data;
  logic [CNT_W-1:0]         o_win_idx;

  modport master (
    output rd_en, rd_addr, sa_clr, sa_en, o_valid, o_data, o_win_idx,
    input  relu_in, o_ready
  );

  modport slave (
    input  rd_en, rd_addr, sa_clr, sa_en, o_valid, o_data, o_win_idx,
    output relu_in, o_ready
  );
endinterface

// File: rtl/pim_readout_ctrl.sv
// Sequencer for the PIM array readout datapath (shift_adder pair -> substract -> relu).
// Per window: clear the shift_adders, stream KERNAL*KERNAL array rows through them, let the
// adders settle for one cycle, then capture all CHANNEL relu results into one word that is
// held on a valid/ready handshake. Runs num_windows windows per start.
// Ports:
//   clk         clock, posedge
//   rst         synchronous active-low reset
//   start       begin a run (only sampled while idle)
//   abort       cancel the current run, back to idle without a done pulse
//   num_windows windows per run, latched when start is accepted
//   busy        high in every state except idle
//   done        one-cycle pulse on normal run completion
//   bus         readout bus (master side): array strobes, relu input, output stream
module pim_readout_ctrl #(
  parameter int unsigned CHANNEL = 10,
  parameter int unsigned KERNAL  = 3,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_windows,
  output logic             busy,
  output logic             done,
  pim_readout_ctrl_if.master bus
);

  localparam int unsigned Win   = KERNAL * KERNAL;
  localparam int unsigned BeatW = (Win > 1) ? $clog2(Win) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Win - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StCapture,
    StHold,
    StDone
  } state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic [CNT_W-1:0]         win_q;
  logic [CNT_W-1:0]         num_q;
  logic [BeatW-1:0]         beat_q;
  logic                     o_valid_q;
  logic [CHANNEL*OUT_W-1:0] o_data_q;
  logic [CNT_W-1:0]         o_win_idx_q;
  logic [CNT_W-1:0]         win_inc;

  assign win_inc = win_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      win_q       <= '0;
      num_q       <= '0;
      beat_q      <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_win_idx_q <= '0;
    end else if (abort && (state_q != StIdle)) begin
      // o_data keeps its last value; only the handshake is withdrawn.
      state_q   <= StIdle;
      o_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            num_q     <= num_windows;
            rd_addr_q <= '0;
            win_q     <= '0;
            state_q   <= (num_windows == '0) ? StDone : StClear;
          end
        end
        StClear: begin
          beat_q  <= '0;
          state_q <= StAccum;
        end
        StAccum: begin
          // Row address runs on across windows and wraps naturally at 2^ADDR_W.
          rd_addr_q <= rd_addr_q + 1'b1;
          beat_q    <= beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          o_data_q    <= bus.relu_in;
          o_win_idx_q <= win_q;
          o_valid_q   <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            win_q     <= win_inc;
            state_q   <= (win_inc == num_q) ? StDone : StClear;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign bus.sa_clr    = (state_q == StClear);
  assign bus.rd_en     = (state_q == StAccum);
  assign bus.sa_en     = (state_q == StAccum);
  assign bus.rd_addr   = rd_addr_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_win_idx = o_win_idx_q;

endmodule

// File: tb/tb_pim_readout_ctrl.sv
// Directed bench for pim_readout_ctrl. Cycle n is the cycle after the edge that accepted
// start (edge 0); outputs are sampled 1 time unit after each posedge.
module tb_pim_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  num_windows;
  logic [39:0] relu_in;
  logic        o_ready;
  logic        busy, done, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] r2;
  int          nv, nd;

  always #5 clk = ~clk;

  pim_readout_ctrl_if #(.CHANNEL(10), .OUT_W(4), .ADDR_W(10), .CNT_W(8)) bus_a ();
  pim_readout_ctrl_if #(.CHANNEL(10), .OUT_W(4), .ADDR_W(4),  .CNT_W(8)) bus_b ();

  assign bus_a.relu_in = relu_in;
  assign bus_a.o_ready = o_ready;
  assign bus_b.relu_in = relu_in;
  assign bus_b.o_ready = o_ready;

  pim_readout_ctrl #(.CHANNEL(10), .KERNAL(3), .OUT_W(4), .ADDR_W(10), .CNT_W(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_windows (num_windows),
    .busy        (busy),
    .done        (done),
    .bus         (bus_a)
  );

  // Narrow-address copy used to observe rd_addr wrap-around.
  pim_readout_ctrl #(.CHANNEL(10), .KERNAL(3), .OUT_W(4), .ADDR_W(4), .CNT_W(8)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_windows (num_windows),
    .busy        (busy_b),
    .done        (done_b),
    .bus         (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel i carries (c + i) mod 16.
  function automatic logic [39:0] pat(input int c);
    logic [39:0] v;
    for (int i = 0; i < 10; i++) v[i*4 +: 4] = 4'(c + i);
    return v;
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; num_windows = 8'd0;
    relu_in = '0; o_ready = 1'b1;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus_a.rd_en, 0);
    check("rst_sa_clr", bus_a.sa_clr, 0);
    check("rst_o_valid", bus_a.o_valid, 0);
    check("rst_rd_addr", bus_a.rd_addr, 0);
    check("rst_o_data", bus_a.o_data, 0);
    rst = 1'b1;
    step();

    // T1: single window
    relu_in = 40'h55_5555_5555; num_windows = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_sa_clr", bus_a.sa_clr, 1);
    check("t1_clr_rd_en", bus_a.rd_en, 0);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 9; k++) begin
      step();
      check("t1_rd_en", bus_a.rd_en, 1);
      check("t1_sa_en", bus_a.sa_en, 1);
      check("t1_acc_sa_clr", bus_a.sa_clr, 0);
      check("t1_rd_addr", bus_a.rd_addr, k);
    end
    step();
    check("t1_cap_rd_en", bus_a.rd_en, 0);
    check("t1_cap_valid", bus_a.o_valid, 0);
    step();
    check("t1_valid", bus_a.o_valid, 1);
    check("t1_data", bus_a.o_data, 40'h55_5555_5555);
    check("t1_idx", bus_a.o_win_idx, 0);
    check("t1_hold_done", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_done_valid", bus_a.o_valid, 0);
    step();
    check("t1_done_end", done, 0);
    check("t1_idle", busy, 0);

    // T2: three windows, start/num_windows poked mid-run must be ignored
    num_windows = 8'd3; start = 1'b1; relu_in = pat(0);
    step();
    start = 1'b0;
    nv = 0; nd = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_a.o_valid) begin
        check("t2_valid_cycle", c, 12 * (nv + 1));
        check("t2_idx", bus_a.o_win_idx, nv);
        check("t2_data", bus_a.o_data, pat(c - 1));
        nv++;
      end
      if (done) begin
        check("t2_done_cycle", c, 37);
        nd++;
      end
      relu_in = pat(c);
      if (c == 5) begin
        start = 1'b1; num_windows = 8'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check("t2_n_valid", nv, 3);
    check("t2_n_done", nd, 1);
    check("t2_rd_addr_end", bus_a.rd_addr, 27);

    // T3: backpressure for 5 cycles on the first window
    num_windows = 8'd2; o_ready = 1'b0; relu_in = 40'hA5_A5A5_A5A5; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 11; c++) step();
    check("t3_cap_valid", bus_a.o_valid, 0);
    r2 = 40'h01_2345_6789;
    for (int c = 12; c <= 16; c++) begin
      step();
      check("t3_stall_valid", bus_a.o_valid, 1);
      check("t3_stall_data", bus_a.o_data, 40'hA5_A5A5_A5A5);
      check("t3_stall_idx", bus_a.o_win_idx, 0);
      check("t3_stall_rd_en", bus_a.rd_en, 0);
      check("t3_stall_sa_clr", bus_a.sa_clr, 0);
      if (c == 14) relu_in = r2;
      if (c == 16) o_ready = 1'b1;
    end
    step();
    check("t3_resume_clr", bus_a.sa_clr, 1);
    check("t3_resume_valid", bus_a.o_valid, 0);
    step();
    check("t3_resume_addr", bus_a.rd_addr, 9);
    check("t3_resume_rd_en", bus_a.rd_en, 1);
    for (int c = 19; c <= 28; c++) step();
    check("t3_valid2", bus_a.o_valid, 1);
    check("t3_idx2", bus_a.o_win_idx, 1);
    check("t3_data2", bus_a.o_data, r2);
    step();
    check("t3_done", done, 1);
    step();

    // T4: abort on ACCUM beat 4, then a fresh run
    num_windows = 8'd1; relu_in = 40'hC3_C3C3_C3C3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    check("t4_beat4_addr", bus_a.rd_addr, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_rd_en", bus_a.rd_en, 0);
    check("t4_valid", bus_a.o_valid, 0);
    check("t4_done", done, 0);
    check("t4_data_kept", bus_a.o_data, r2);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t4_no_done", done, 0);
    end
    abort = 1'b1; start = 1'b1;
    step();
    check("t4_abort_start_idle", busy, 0);
    abort = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_restart_clr", bus_a.sa_clr, 1);
    step();
    check("t4_restart_addr", bus_a.rd_addr, 0);
    for (int c = 3; c <= 12; c++) step();
    check("t4_valid2", bus_a.o_valid, 1);
    check("t4_data2", bus_a.o_data, 40'hC3_C3C3_C3C3);
    step();
    check("t4_done2", done, 1);
    step();

    // T5: zero windows, start held while busy; then abort during DONE
    num_windows = 8'd0; start = 1'b1;
    step();
    check("t5_busy", busy, 1);
    check("t5_done", done, 1);
    check("t5_no_clr", bus_a.sa_clr, 0);
    check("t5_no_rd", bus_a.rd_en, 0);
    step();
    start = 1'b0;
    check("t5_idle", busy, 0);
    check("t5_done_end", done, 0);
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b1;
    check("t5_abort_done", done, 1);
    step();
    abort = 1'b0;
    check("t5_abort_idle", busy, 0);
    check("t5_abort_done_end", done, 0);

    // T6: reset while in HOLD, then rd_addr wrap on the 4-bit copy
    num_windows = 8'd2; o_ready = 1'b0; relu_in = 40'h99_9999_9999; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) step();
    check("t6_hold_valid", bus_a.o_valid, 1);
    rst = 1'b0;
    step();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", bus_a.o_valid, 0);
    check("t6_rst_data", bus_a.o_data, 0);
    check("t6_rst_idx", bus_a.o_win_idx, 0);
    check("t6_rst_addr", bus_a.rd_addr, 0);
    check("t6_rst_done", done, 0);
    rst = 1'b1; o_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 13; c++) step();
    check("t6_b_clr2", bus_b.sa_clr, 1);
    for (int k = 0; k < 9; k++) begin
      step();
      check("t6_b_wrap_addr", bus_b.rd_addr, (9 + k) % 16);
      check("t6_a_addr", bus_a.rd_addr, 9 + k);
    end
    step();
    step();
    check("t6_b_idx", bus_b.o_win_idx, 1);
    step();
    check("t6_b_done", done_b, 1);
    check("t6_b_addr_end", bus_b.rd_addr, 2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
